// File: rtl/cacheline_burst_adapter_pkg.sv
// Shared types and size helpers for the cacheline/burst adapter.
// BEATS is the number of bus words per line; CNT_W is the width of the beat counters.
package cache_adapter_pkg;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_BURST = 1'b1
    } w_state_t;

    function automatic int calc_beats(input int line_w, input int bus_w);
        return line_w / bus_w;
    endfunction

    function automatic int calc_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/cacheline_burst_adapter_deser.sv
// Collects in-order read-return beats into a full cacheline.
// Gaps are tolerated; the tag of beat 0 is the reference for the rest of the burst.
module burst_deserializer
    import cache_adapter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BUS_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_valid,
    input  logic [ADDR_W-1:0] beat_addr,
    input  logic [BUS_W-1:0]  beat_data,
    output logic              line_valid,
    output logic [ADDR_W-1:0] line_addr,
    output logic [LINE_W-1:0] line_data,
    output logic              err_addr
);

    localparam int BEATS = calc_beats(LINE_W, BUS_W);
    localparam int CNT_W = calc_cnt_w(BEATS);

    logic [CNT_W-1:0]  rcnt_reg;
    logic [ADDR_W-1:0] raddr_reg;
    logic [BUS_W-1:0]  rbuf [BEATS];
    logic [LINE_W-1:0] line_cat;
    logic              last_beat;

    assign last_beat = (rcnt_reg == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_reg  <= '0;
            raddr_reg <= '0;
        end else if (beat_valid) begin
            rcnt_reg <= rcnt_reg + CNT_W'(1);
            if (rcnt_reg == '0) begin
                raddr_reg <= beat_addr;
            end
        end
    end

    // The slot written on the final beat is never read; the final beat goes straight to the output.
    always_ff @(posedge clk) begin
        if (beat_valid) begin
            rbuf[rcnt_reg] <= beat_data;
        end
    end

    for (genvar gi = 0; gi < BEATS - 1; gi++) begin : g_line
        assign line_cat[gi*BUS_W +: BUS_W] = rbuf[gi];
    end
    assign line_cat[LINE_W-1 -: BUS_W] = beat_data;

    assign line_valid = beat_valid & last_beat & ~rst;
    assign line_addr  = line_valid ? raddr_reg : '0;
    assign line_data  = line_valid ? line_cat : '0;
    assign err_addr   = beat_valid & (rcnt_reg != '0) & (beat_addr != raddr_reg) & ~rst;

endmodule

// File: rtl/cacheline_burst_adapter.sv
// Bridges a line-wide cache port to a narrow burst memory port.
// Writes are latched and serialised LSB beat first; reads pass through and are reassembled.
module cacheline_burst_adapter
    import cache_adapter_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int LINE_W          = 256,
    parameter int BUS_W           = 64,
    parameter int WRITE_EARLY_ACK = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ufp_addr,
    input  logic              ufp_read,
    input  logic              ufp_write,
    input  logic [LINE_W-1:0] ufp_wdata,
    output logic              ufp_ready,
    output logic [ADDR_W-1:0] ufp_raddr,
    output logic [LINE_W-1:0] ufp_rdata,
    output logic              ufp_rvalid,
    output logic [ADDR_W-1:0] dfp_addr,
    output logic              dfp_read,
    output logic              dfp_write,
    output logic [BUS_W-1:0]  dfp_wdata,
    input  logic              dfp_ready,
    input  logic [ADDR_W-1:0] dfp_raddr,
    input  logic [BUS_W-1:0]  dfp_rdata,
    input  logic              dfp_rvalid,
    output logic              err_raddr
);

    localparam int BEATS = calc_beats(LINE_W, BUS_W);
    localparam int CNT_W = calc_cnt_w(BEATS);

    w_state_t          state_reg, state_next;
    logic [CNT_W-1:0]  wcnt_reg, wcnt_next;
    logic [ADDR_W-1:0] waddr_reg;
    logic [BUS_W-1:0]  wbuf [BEATS];
    logic [BUS_W-1:0]  wbeat;
    logic              wr_accept;

    assign wbeat = wbuf[wcnt_reg];

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        wr_accept  = 1'b0;
        ufp_ready  = 1'b0;
        dfp_read   = 1'b0;
        dfp_write  = 1'b0;
        dfp_addr   = ufp_addr;
        dfp_wdata  = ufp_wdata[BUS_W-1:0];

        case (state_reg)
            W_IDLE: begin
                // A write request masks any simultaneous read.
                if (ufp_write) begin
                    dfp_write = 1'b1;
                    if (dfp_ready) begin
                        wr_accept  = 1'b1;
                        wcnt_next  = CNT_W'(1);
                        state_next = W_BURST;
                        ufp_ready  = (WRITE_EARLY_ACK != 0);
                    end
                end else begin
                    dfp_read  = ufp_read;
                    ufp_ready = ufp_read & dfp_ready;
                end
            end
            W_BURST: begin
                dfp_write = 1'b1;
                dfp_addr  = waddr_reg;
                dfp_wdata = wbeat;
                if (dfp_ready) begin
                    wcnt_next = wcnt_reg + CNT_W'(1);
                    if (wcnt_reg == CNT_W'(BEATS - 1)) begin
                        state_next = W_IDLE;
                        ufp_ready  = (WRITE_EARLY_ACK == 0);
                    end
                end
            end
            default: begin
                state_next = W_IDLE;
            end
        endcase

        if (rst) begin
            wr_accept = 1'b0;
            ufp_ready = 1'b0;
            dfp_read  = 1'b0;
            dfp_write = 1'b0;
            dfp_addr  = '0;
            dfp_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= W_IDLE;
            wcnt_reg  <= '0;
            waddr_reg <= '0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            if (wr_accept) begin
                waddr_reg <= ufp_addr;
            end
        end
    end

    // The whole line is captured at acceptance so the cache may change ufp_wdata afterwards.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < BEATS; i++) begin
                wbuf[i] <= ufp_wdata[i*BUS_W +: BUS_W];
            end
        end
    end

    burst_deserializer #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .BUS_W  (BUS_W)
    ) u_deser (
        .clk        (clk),
        .rst        (rst),
        .beat_valid (dfp_rvalid),
        .beat_addr  (dfp_raddr),
        .beat_data  (dfp_rdata),
        .line_valid (ufp_rvalid),
        .line_addr  (ufp_raddr),
        .line_data  (ufp_rdata),
        .err_addr   (err_raddr)
    );

endmodule
